// File: rtl/reg_bus_master_if.sv
// Request/response handshake and bus strobes for reg_bus_master.
// master: the sequencer side; slave: the core/regfile side. Data bus is a top port.
interface reg_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata1;
  logic [31:0] rsp_rdata2;
  logic        bus_rd;
  logic        bus_wr;
  logic [4:0]  bus_addr;

  modport master (
    input  req_valid, req_op, req_rs1,
    input  req_rs2, req_rd, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata1, rsp_rdata2,
    output bus_rd, bus_wr, bus_addr
  );

  modport slave (
    output req_valid, req_op, req_rs1,
    output req_rs2, req_rd, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata1, rsp_rdata2,
    input  bus_rd, bus_wr, bus_addr
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register bus sequencer: READ1/READ2/WRITE/COPY as rd/ta/wr bus phases.
// Ports: clk, rst (async high), rb (master modport), bus (shared inout data).
// Option: REG_BUS_X0_SHORTCUT_EN suppresses strobes for address-0 phases.
module reg_bus_master (
  input  logic               clk,
  input  logic               rst,
  reg_bus_master_if.master   rb,
  inout  wire  [31:0]        bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD1,
    S_RD2,
    S_TA,
    S_WR
  } state_t;

  localparam logic [1:0] OP_RD1 = 2'b00;
  localparam logic [1:0] OP_RD2 = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_CP  = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } req_t;

  state_t      st;
  state_t      st_d;
  req_t        rq;
  logic [31:0] cap1;
  logic        acc;
  logic        rd_en;
  logic        wr_en;
  logic [4:0]  addr;
  logic [31:0] samp;
  logic [31:0] wdrv;
  logic        rsp_q;
  logic [31:0] r1_q;
  logic [31:0] r2_q;
  logic        rd1_last;
  logic        cp_last;

  assign rb.req_ready = (st == S_IDLE) && !rst;
  assign acc = rb.req_valid && rb.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_d;
  end

  always_comb begin
    st_d = st;
    unique case (st)
      S_IDLE: begin
        if (acc)
          st_d = (rb.req_op == OP_WR) ? S_WR : S_RD1;
      end
      S_RD1: begin
        unique case (rq.op)
          OP_RD2:  st_d = S_RD2;
          OP_CP:   st_d = S_TA;
          default: st_d = S_IDLE;
        endcase
      end
      S_RD2:   st_d = S_IDLE;
      S_TA:    st_d = S_WR;
      S_WR:    st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = 5'd0;
    unique case (st)
      S_RD1: begin
        rd_en = 1'b1;
        addr  = rq.rs1;
      end
      S_RD2: begin
        rd_en = 1'b1;
        addr  = rq.rs2;
      end
      S_WR: begin
        wr_en = 1'b1;
        addr  = rq.rd;
      end
      default: ;
    endcase
`ifdef REG_BUS_X0_SHORTCUT_EN
    // x0 phases keep their slot but never touch the bus
    if (addr == 5'd0) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
`endif
  end

  // a read phase without a strobe can only be the x0 shortcut
  assign samp = rd_en ? bus : 32'h0;
  assign wdrv = (rq.op == OP_WR) ? rq.wdata : cap1;
  assign bus  = wr_en ? wdrv : 32'hzzzz_zzzz;

  assign rd1_last = (st == S_RD1) && (rq.op == OP_RD1);
  assign cp_last  = (st == S_WR) && (rq.op == OP_CP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq    <= '0;
      cap1  <= 32'h0;
      rsp_q <= 1'b0;
      r1_q  <= 32'h0;
      r2_q  <= 32'h0;
    end else begin
      rsp_q <= rd1_last || (st == S_RD2) || (st == S_WR);
      if (acc)
        rq <= {rb.req_op, rb.req_rs1, rb.req_rs2,
               rb.req_rd, rb.req_wdata};
      if (st == S_RD1)
        cap1 <= samp;
      // response data changes only with the pulse
      unique case (1'b1)
        rd1_last: r1_q <= samp;
        st == S_RD2: begin
          r1_q <= cap1;
          r2_q <= samp;
        end
        cp_last: r1_q <= cap1;
        default: ;
      endcase
    end
  end

  assign rb.rsp_valid  = rsp_q;
  assign rb.rsp_rdata1 = r1_q;
  assign rb.rsp_rdata2 = r2_q;
  assign rb.bus_rd     = rd_en;
  assign rb.bus_wr     = wr_en;
  assign rb.bus_addr   = addr;

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master: regfile responder, op-level model,
// per-cycle compare, directed literal checks and randomized op streams.
module tb_reg_bus_master;

`ifdef REG_BUS_X0_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  localparam int P_NONE = 0;
  localparam int P_RDA  = 1;
  localparam int P_RDB  = 2;
  localparam int P_TA   = 3;
  localparam int P_WR   = 4;
  localparam int P_RSP  = 5;

  localparam int K_PROBE = 0;
  localparam int K_VAL   = 1;
  localparam int K_DC    = 2;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          rsp;
    logic [4:0]  addr;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [31:0] bus;

  reg_bus_master_if rb();

  reg_bus_master dut (
    .clk (clk),
    .rst (rst),
    .rb  (rb),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] rf [32];
  logic [31:0] mregs [32];
  logic        load_rf = 1'b1;
  logic        probe_cur = 1'b1;
  logic [31:0] probe_val = 32'h0;
  logic        acc_flag = 1'b0;

  bit          f_valid = 1'b0;
  int          f_start = 0;
  logic [1:0]  f_op;
  logic [4:0]  f_rs1, f_rs2, f_rd;
  logic [31:0] f_wd, f_v1, f_v2;
  logic [31:0] m_r1 = 32'h0;
  logic [31:0] m_r2 = 32'h0;

  // register file responder and release probe on the shared bus
  assign bus = rb.bus_rd ? rf[rb.bus_addr] : 32'hzzzz_zzzz;
  assign bus = (rst || probe_cur) ? probe_val : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (load_rf)
      rf <= mregs;
    else if (rb.bus_wr && rb.bus_addr != 5'd0)
      rf[rb.bus_addr] <= bus;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int len_of(input logic [1:0] op);
    case (op)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int ph_of(input logic [1:0] op, input int k);
    if (k == len_of(op)) return P_RSP;
    if (k > len_of(op)) return P_NONE;
    case (op)
      2'b00: return P_RDA;
      2'b01: return (k == 0) ? P_RDA : P_RDB;
      2'b10: return P_WR;
      default: begin
        if (k == 0) return P_RDA;
        if (k == 1) return P_TA;
        return P_WR;
      end
    endcase
  endfunction

  function automatic bit m_ready(input int c);
    return !rst && !(f_valid && c < f_start + len_of(f_op));
  endfunction

  function automatic exp_t exp_at(input int c);
    exp_t e;
    e.rd = 1'b0;
    e.wr = 1'b0;
    e.rsp = 1'b0;
    e.addr = 5'd0;
    e.kind = K_PROBE;
    e.val = 32'h0;
    if (f_valid && c >= f_start) begin
      case (ph_of(f_op, c - f_start))
        P_RDA: begin
          e.addr = f_rs1;
          e.rd = !(SC && f_rs1 == 5'd0);
          e.kind = e.rd ? K_DC : K_PROBE;
        end
        P_RDB: begin
          e.addr = f_rs2;
          e.rd = !(SC && f_rs2 == 5'd0);
          e.kind = e.rd ? K_DC : K_PROBE;
        end
        P_WR: begin
          e.addr = f_rd;
          e.wr = !(SC && f_rd == 5'd0);
          e.kind = e.wr ? K_VAL : K_PROBE;
          e.val = (f_op == 2'b10) ? f_wd : f_v1;
        end
        P_RSP: e.rsp = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // model: advances at each edge, closing cycle cyc
  always @(posedge clk) begin
    if (!rst) begin
      if (f_valid && cyc >= f_start &&
          ph_of(f_op, cyc - f_start) == P_WR && f_rd != 5'd0)
        mregs[f_rd] = (f_op == 2'b10) ? f_wd : f_v1;
      if (rb.req_valid && m_ready(cyc)) begin
        f_valid = 1'b1;
        f_start = cyc + 1;
        f_op  = rb.req_op;
        f_rs1 = rb.req_rs1;
        f_rs2 = rb.req_rs2;
        f_rd  = rb.req_rd;
        f_wd  = rb.req_wdata;
        f_v1  = mregs[rb.req_rs1];
        f_v2  = mregs[rb.req_rs2];
        acc_flag = 1'b1;
      end
    end
    cyc++;
    if (f_valid && cyc == f_start + len_of(f_op)) begin
      if (f_op != 2'b10) m_r1 = f_v1;
      if (f_op == 2'b01) m_r2 = f_v2;
    end
    probe_cur = (exp_at(cyc).kind == K_PROBE);
    probe_val = $urandom;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      f_valid = 1'b0;
      m_r1 = 32'h0;
      m_r2 = 32'h0;
    end
    e = exp_at(cyc);
    chk("ready", 32'(rb.req_ready), 32'(m_ready(cyc)));
    chk("bus_rd", 32'(rb.bus_rd), 32'(e.rd));
    chk("bus_wr", 32'(rb.bus_wr), 32'(e.wr));
    chk("bus_addr", 32'(rb.bus_addr), 32'(e.addr));
    chk("rsp_valid", 32'(rb.rsp_valid), 32'(e.rsp));
    chk("rdata1", rb.rsp_rdata1, m_r1);
    chk("rdata2", rb.rsp_rdata2, m_r2);
    if (e.kind == K_PROBE)
      chk("bus_released", bus, probe_val);
    else if (e.kind == K_VAL)
      chk("bus_wdata", bus, e.val);
  end

  task automatic present(input logic [1:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d,
                         input logic [31:0] w);
    rb.req_valid = 1'b1;
    rb.req_op    = op;
    rb.req_rs1   = a;
    rb.req_rs2   = b;
    rb.req_rd    = d;
    rb.req_wdata = w;
  endtask

  task automatic wait_acc();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_flag && n < 40);
    if (!acc_flag) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got none want accept (cycle %0d)", cyc);
    end
    acc_flag = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rb.req_valid = 1'b0;
    rb.req_op    = 2'b00;
    rb.req_rs1   = 5'd0;
    rb.req_rs2   = 5'd0;
    rb.req_rd    = 5'd0;
    rb.req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) mregs[i] = $urandom;
    mregs[0] = 32'h0;
    mregs[3] = 32'h1234_5678;
    mregs[9] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(rb.req_ready), 32'h0);
    chk("reset_rdata1", rb.rsp_rdata1, 32'h0);
    load_rf = 1'b0;
    rst = 1'b0;
    next_cyc();

    // WRITE r5
    present(2'b10, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    chk("w_wr", 32'(rb.bus_wr), 32'h1);
    chk("w_addr", 32'(rb.bus_addr), 32'd5);
    chk("w_bus", bus, 32'hDEAD_BEEF);
    chk("w_rsp_early", 32'(rb.rsp_valid), 32'h0);
    @(negedge clk);
    chk("w_rsp", 32'(rb.rsp_valid), 32'h1);
    @(negedge clk);
    chk("w_rsp_pulse", 32'(rb.rsp_valid), 32'h0);
    next_cyc();

    // READ2 r5,r3
    present(2'b01, 5'd5, 5'd3, 5'd0, 32'h0);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    chk("r2_rd_a", 32'(rb.bus_rd), 32'h1);
    chk("r2_addr_a", 32'(rb.bus_addr), 32'd5);
    @(negedge clk);
    chk("r2_rd_b", 32'(rb.bus_rd), 32'h1);
    chk("r2_addr_b", 32'(rb.bus_addr), 32'd3);
    @(negedge clk);
    chk("r2_rsp", 32'(rb.rsp_valid), 32'h1);
    chk("r2_d1", rb.rsp_rdata1, 32'hDEAD_BEEF);
    chk("r2_d2", rb.rsp_rdata2, 32'h1234_5678);
    next_cyc();

    // COPY r5->r7 then READ1 r7 in its response cycle
    present(2'b11, 5'd5, 5'd0, 5'd7, 32'h0);
    wait_acc();
    present(2'b00, 5'd7, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    chk("cp_rd", 32'(rb.bus_rd), 32'h1);
    chk("cp_rd_addr", 32'(rb.bus_addr), 32'd5);
    @(negedge clk);
    chk("cp_ta_rd", 32'(rb.bus_rd), 32'h0);
    chk("cp_ta_wr", 32'(rb.bus_wr), 32'h0);
    chk("cp_ta_addr", 32'(rb.bus_addr), 32'd0);
    @(negedge clk);
    chk("cp_wr", 32'(rb.bus_wr), 32'h1);
    chk("cp_wr_addr", 32'(rb.bus_addr), 32'd7);
    chk("cp_bus", bus, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("cp_rsp", 32'(rb.rsp_valid), 32'h1);
    chk("cp_ready", 32'(rb.req_ready), 32'h1);
    chk("cp_d1", rb.rsp_rdata1, 32'hDEAD_BEEF);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    chk("rb_addr", 32'(rb.bus_addr), 32'd7);
    @(negedge clk);
    chk("rb_rsp", 32'(rb.rsp_valid), 32'h1);
    chk("rb_d1", rb.rsp_rdata1, 32'hDEAD_BEEF);
    next_cyc();

    // reset in the turnaround of COPY r5->r9
    present(2'b11, 5'd5, 5'd0, 5'd9, 32'h0);
    wait_acc();
    rb.req_valid = 1'b0;
    next_cyc();
    rst = 1'b1;
    #1;
    chk("rst_rd", 32'(rb.bus_rd), 32'h0);
    chk("rst_wr", 32'(rb.bus_wr), 32'h0);
    chk("rst_ready", 32'(rb.req_ready), 32'h0);
    @(negedge clk);
    chk("rst_rsp", 32'(rb.rsp_valid), 32'h0);
    next_cyc();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rb.rsp_valid), 32'h0);
    end
    next_cyc();
    present(2'b00, 5'd5, 5'd0, 5'd0, 32'h0);
    wait_acc();
    present(2'b00, 5'd9, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rr5_d1", rb.rsp_rdata1, 32'hDEAD_BEEF);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr9_rsp", 32'(rb.rsp_valid), 32'h1);
    chk("rr9_d1", rb.rsp_rdata1, 32'h0);
    next_cyc();

    // address 0 phases
    present(2'b00, 5'd0, 5'd0, 5'd0, 32'h0);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    chk("x0_rd", 32'(rb.bus_rd), SC ? 32'h0 : 32'h1);
    chk("x0_rd_addr", 32'(rb.bus_addr), 32'd0);
    @(negedge clk);
    chk("x0_rd_rsp", 32'(rb.rsp_valid), 32'h1);
    chk("x0_rd_d1", rb.rsp_rdata1, 32'h0);
    next_cyc();
    present(2'b10, 5'd0, 5'd0, 5'd0, 32'hA5A5_A5A5);
    wait_acc();
    rb.req_valid = 1'b0;
    @(negedge clk);
    chk("x0_wr", 32'(rb.bus_wr), SC ? 32'h0 : 32'h1);
    @(negedge clk);
    chk("x0_wr_rsp", 32'(rb.rsp_valid), 32'h1);
    next_cyc();

    // held valid, alternating ops
    for (int i = 0; i < 12; i++) begin
      present(2'(i % 4), 5'($urandom_range(0, 9)),
              5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
              $urandom);
      wait_acc();
    end
    rb.req_valid = 1'b0;
    repeat (4) next_cyc();

    // randomized streams with gaps and occasional reset
    for (int i = 0; i < 400; i++) begin
      present(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom);
      wait_acc();
      if ($urandom_range(0, 29) == 0) begin
        rb.req_valid = 1'b0;
        repeat ($urandom_range(0, 3)) next_cyc();
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) next_cyc();
        rst = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        rb.req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) next_cyc();
      end
    end
    rb.req_valid = 1'b0;
    repeat (6) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got running want finished (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Sequencing initiator for the shared tristate register bus (`rd`/`wr`/`addr`/`bus`) that the register file responds on. It accepts one register operation at a time through a valid/ready request port and issues the correct sequence of bus cycles:
- single read
- dual operand read
- write
- register-to-register copy

It then reports completion with a one-cycle response pulse. It sits between the core control path and the register file, and is the only block that asserts the bus strobes.

## Interface
- No parameters; data width 32, register address width 5 (32 registers).
- `clk`  in  1  rising-edge clock shared with the register file.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE and only while `rst` is low.
- `req_op`  in  2  operation code:
  - 00 READ1
  - 01 READ2
  - 10 WRITE
  - 11 COPY
- `req_rs1`  in  5  first source register.
- `req_rs2`  in  5  second source register (READ2 only).
- `req_rd`  in  5  destination register (WRITE, COPY).
- `req_wdata`  in  32  write data (WRITE only).
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata1`  out  32  value of rs1 (READ1/READ2/COPY); held until the next response.
- `rsp_rdata2`  out  32  value of rs2 (READ2); held until the next response.
- `bus_rd`  out  1  register file read strobe.
- `bus_wr`  out  1  register file write strobe.
- `bus_addr`  out  5  register address.
- `bus`  inout  32  shared data bus; driven only while `bus_wr`=1, otherwise high-Z.

## Operation
- States: IDLE, RD1, RD2, TA, WR.
- Handshake: a request is accepted on a rising edge where `req_valid` && `req_ready`. All request fields are latched at that edge, so inputs may change afterwards.
- Transitions after acceptance:
  - READ1: RD1 → IDLE
  - READ2: RD1 → RD2 → IDLE
  - WRITE: WR → IDLE
  - COPY: RD1 → TA → WR → IDLE
- RD1 state: `bus_rd`=1, `bus_addr`=rs1. `bus` is sampled into the rdata1 holding register at the closing edge.
- RD2 state: `bus_rd`=1, `bus_addr`=rs2. `bus` is sampled into the rdata2 holding register at the closing edge.
- TA state: `bus_rd`=`bus_wr`=0, `bus` released. This mandatory turnaround guarantees the responder stops driving before the master drives.
- WR state: `bus_wr`=1, `bus_addr`=rd. `bus` is driven with `req_wdata` (WRITE) or with the captured rs1 value (COPY).
- Response: `rsp_valid` pulses in the first IDLE cycle after the last phase. For COPY, `rsp_rdata1` = copied value. For WRITE, `rsp_rdata1`/`rsp_rdata2` are unchanged.
- Bus invariants:
  - `bus_rd` and `bus_wr` are never high in the same cycle.
  - `bus_addr`=0 whenever both strobes are low.
  - `bus` is high-Z in every state except WR.
- Unknown ops: none exist, because all four codes are defined.

## Timing
- Request accepted at edge N; the first bus phase occupies cycle N+1.
- `rsp_valid` is high in cycle:
  - READ1: N+2
  - READ2: N+3
  - WRITE: N+2
  - COPY: N+4
- Back-to-back: `req_ready`=1 during the `rsp_valid` cycle, so a new request may be accepted there. Its first phase follows immediately.
- Write-then-read: a WRITE commits at the closing edge of its WR cycle. A read accepted at or after the response cycle observes the new value.
- Read data is combinational from the responder within the RD cycle and is captured at that cycle's closing edge. No extra latency is added.
- Reset values:
  - state IDLE
  - `req_ready`=0 while `rst` is high
  - `rsp_valid`=0
  - `rsp_rdata1`=`rsp_rdata2`=0
  - `bus_rd`=`bus_wr`=0
  - `bus_addr`=0
  - `bus` high-Z
- Reset mid-operation: strobes drop and `bus` is released asynchronously, within the same cycle `rst` rises. The in-flight operation is discarded with no response. A WR cycle cut by reset before its closing edge does not write.

## Configuration
- `REG_BUS_X0_SHORTCUT_EN` defined:
  - Any RD1/RD2 phase whose address is 0 keeps `bus_rd`=0 and captures 32'h0 instead of sampling `bus`.
  - Any WR phase with rd=0 keeps `bus_wr`=0 and leaves `bus` high-Z.
  - State sequence and all latencies are identical to the undefined case.
- Not defined: address-0 phases issue normal strobes. The register file's own x0 handling applies.

## Test plan
- Reset, then WRITE rd=5, wdata=32'hDEADBEEF accepted at N → cycle N+1: `bus_wr`=1, `bus_addr`=5, `bus`=DEADBEEF. `rsp_valid` at N+2 only.
- READ2 rs1=5, rs2=3 (reg3=32'h12345678) → `bus_rd` high N+1 (addr 5) and N+2 (addr 3). `rsp_valid` at N+3 with rdata1=DEADBEEF, rdata2=12345678.
- COPY rs1=5, rd=7, then READ1 rs1=7 accepted in the COPY response cycle → COPY phases RD/TA/WR, with `bus` high-Z and both strobes 0 in TA. READ1 returns DEADBEEF.
- Hold `req_valid`=1 with alternating ops → `req_ready` low in every non-IDLE cycle. Each request is accepted exactly once; there are never two strobes or bus contention in any cycle.
- Assert `rst` during the TA cycle of COPY rs1=5, rd=9 (reg9=0) → strobes 0 and `bus` high-Z immediately. No `rsp_valid`. Subsequent READ1 of reg9 returns 0.
- With `REG_BUS_X0_SHORTCUT_EN`: WRITE rd=0 → `bus_wr` never asserted, response at N+2. READ1 rs1=0 → `bus_rd`=0, rdata1=0 at N+2. Without the macro: READ1 rs1=0 shows `bus_rd`=1 with `bus_addr`=0.
